// File: rtl/spi_param_regs_if.sv
// spi_param_regs_if: signal bundle between the SPI front end and the parameter register file.
//   master : drives cs, sck and frame. Observes kp, ki, kd, setpoint, update and frame_err.
//   slave  : the register file. Observes cs, sck and frame. Drives the register outputs and pulses.
//   cs     : raw SPI chip select, active low
//   sck    : raw SPI clock
//   frame  : shifter output word {addr, data}
interface spi_param_regs_if #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned REG_W      = 8
);
  logic                  cs;
  logic                  sck;
  logic [FRAME_BITS-1:0] frame;
  logic [REG_W-1:0]      kp;
  logic [REG_W-1:0]      ki;
  logic [REG_W-1:0]      kd;
  logic [REG_W-1:0]      setpoint;
  logic                  update;
  logic                  frame_err;

  modport master (
    output cs, sck, frame,
    input  kp, ki, kd, setpoint, update, frame_err
  );

  modport slave (
    input  cs, sck, frame,
    output kp, ki, kd, setpoint, update, frame_err
  );
endinterface

// File: rtl/spi_param_regs.sv
// spi_param_regs: SPI frame decoder and PID parameter register file.
//   Synchronizes raw cs/sck, counts sck falling edges inside each cs-low window and, once cs
//   rises, checks the frame length and decodes the shifter word as {addr, data}. A good frame
//   writes data into register addr (0=kp, 1=ki, 2=kd, 3=setpoint) and pulses update. A bad
//   frame (wrong length or address out of range) pulses frame_err instead.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : spi_param_regs_if slave (cs, sck, frame in; kp, ki, kd, setpoint, update,
//           frame_err out)
// Configuration macro: SPI_PARAM_SHADOW_EN
//   When it is defined, writes land in shadow registers. A frame whose addr is all ones copies
//   every shadow to the outputs at once and pulses update.
//   When it is undefined, writes go straight to the outputs and an all-ones addr is an error.
module spi_param_regs #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned REG_W      = 8,
  parameter int unsigned NREGS      = 4
) (
  input logic             clk,
  input logic             reset,
  spi_param_regs_if.slave bus
);

  localparam int unsigned ADDR_W = FRAME_BITS - REG_W;
  localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {StIdle, StActive, StCheck} state_e;

  // [0] is the metastability stage, [1] is the synchronized value
  logic [1:0]       r_cs_sync;
  logic [1:0]       r_sck_sync;
  logic             r_cs_prev;
  logic             r_sck_prev;
  logic [CNT_W-1:0] r_bit_cnt;
  state_e           r_state;
  logic             r_fall_pend;
  logic             r_update;
  logic             r_frame_err;
  logic [REG_W-1:0] r_regs [NREGS];
`ifdef SPI_PARAM_SHADOW_EN
  logic [REG_W-1:0] r_shadow [NREGS];
`endif

  logic              w_cs_s;
  logic              w_sck_s;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_sck_fall;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_addr_ext;
  logic [REG_W-1:0]  w_data;
  logic              w_len_ok;
  logic              w_addr_in;

  assign w_cs_s     = r_cs_sync[1];
  assign w_sck_s    = r_sck_sync[1];
  assign w_cs_fall  = ~w_cs_s & r_cs_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;
  assign w_sck_fall = ~w_sck_s & r_sck_prev;

  assign w_addr     = bus.frame[FRAME_BITS-1:REG_W];
  assign w_addr_ext = 32'(w_addr);
  assign w_data     = bus.frame[REG_W-1:0];
  assign w_len_ok   = (r_bit_cnt == CntFull);
  assign w_addr_in  = (w_addr_ext < NREGS);

  // cs idles high and sck idles low, so the reset values create no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs_sync  <= 2'b11;
      r_sck_sync <= 2'b00;
      r_cs_prev  <= 1'b1;
      r_sck_prev <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[0], bus.cs};
      r_sck_sync <= {r_sck_sync[0], bus.sck};
      r_cs_prev  <= w_cs_s;
      r_sck_prev <= w_sck_s;
    end
  end

  // Saturating at FRAME_BITS+1 keeps an overlong frame distinct from a full one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
    end else if (w_cs_fall) begin
      r_bit_cnt <= '0;
    end else if (w_sck_fall && !w_cs_s && (r_bit_cnt != CntSat)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_fall_pend <= 1'b0;
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
`ifdef SPI_PARAM_SHADOW_EN
        r_shadow[i] <= '0;
`endif
      end
    end else begin
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A fall seen during CHECK was parked in r_fall_pend so the next frame is kept.
          if (w_cs_fall || r_fall_pend) begin
            r_state     <= StActive;
            r_fall_pend <= 1'b0;
          end
        end
        StActive: begin
          if (w_cs_rise) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          r_state     <= StIdle;
          r_fall_pend <= w_cs_fall;
`ifdef SPI_PARAM_SHADOW_EN
          if (w_len_ok && (&w_addr)) begin
            r_regs   <= r_shadow;
            r_update <= 1'b1;
          end else if (w_len_ok && w_addr_in) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (w_addr_ext == i) begin
                r_shadow[i] <= w_data;
              end
            end
          end else begin
            r_frame_err <= 1'b1;
          end
`else
          if (w_len_ok && w_addr_in) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (w_addr_ext == i) begin
                r_regs[i] <= w_data;
              end
            end
            r_update <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.kp        = r_regs[0];
  assign bus.ki        = r_regs[1];
  assign bus.kd        = r_regs[2];
  assign bus.setpoint  = r_regs[3];
  assign bus.update    = r_update;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_param_regs.sv
// tb_spi_param_regs: directed and randomized frames checked against a register-level model.
module tb_spi_param_regs;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;
  int upd_cnt;
  int err_cnt;
  int both_cnt;

  logic [7:0] m_regs [4];
  logic [7:0] m_shadow [4];

  spi_param_regs_if #(.FRAME_BITS(16), .REG_W(8)) bus ();

  spi_param_regs #(
    .FRAME_BITS(16),
    .REG_W     (8),
    .NREGS     (4)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.update === 1'b1) upd_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.update === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Register-level model: a frame counts only with exactly 16 sck pulses.
  task automatic model_frame(input logic [15:0] w, input int nsck,
                             output int exp_upd, output int exp_err);
    int a;
    a = int'(w[15:8]);
    exp_upd = 0;
    exp_err = 0;
    if (nsck != 16) begin
      exp_err = 1;
`ifdef SPI_PARAM_SHADOW_EN
    end else if (a == 255) begin
      for (int i = 0; i < 4; i++) m_regs[i] = m_shadow[i];
      exp_upd = 1;
    end else if (a < 4) begin
      m_shadow[a] = w[7:0];
`else
    end else if (a < 4) begin
      m_regs[a] = w[7:0];
      exp_upd = 1;
`endif
    end else begin
      exp_err = 1;
    end
  endtask

  // Leaves cs high right after a negedge, with the word on frame.
  task automatic send(input logic [15:0] w, input int nsck);
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nsck; i++) begin
      bus.sck = 1'b1;
      repeat (2) @(negedge clk);
      bus.sck = 1'b0;
      repeat (2) @(negedge clk);
    end
    bus.frame = w;
    bus.cs    = 1'b1;
  endtask

  task automatic settle_check(input string tag, input int upd_base, input int err_base,
                              input int exp_upd, input int exp_err);
    repeat (8) @(negedge clk);
    check({tag, ".kp"}, 32'(bus.kp), 32'(m_regs[0]));
    check({tag, ".ki"}, 32'(bus.ki), 32'(m_regs[1]));
    check({tag, ".kd"}, 32'(bus.kd), 32'(m_regs[2]));
    check({tag, ".setpoint"}, 32'(bus.setpoint), 32'(m_regs[3]));
    check({tag, ".updates"}, 32'(upd_cnt - upd_base), 32'(exp_upd));
    check({tag, ".errors"}, 32'(err_cnt - err_base), 32'(exp_err));
  endtask

  initial begin
    int ub, eb, eu, ee, eu2, ee2;
    logic [15:0] w;
    int nsck;
    logic [7:0] a;

    n_vec = 0; n_err = 0; upd_cnt = 0; err_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 8'h00;
      m_shadow[i] = 8'h00;
    end
    rst_n = 1'b0;
    bus.cs = 1'b1;
    bus.sck = 1'b0;
    bus.frame = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    settle_check("reset", 0, 0, 0, 0);

    // Single write with exact latency: cs_s rises 2 clk after cs, outputs 2 clk later.
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0142, 16, eu, ee);
    send(16'h0142, 16);
    repeat (3) @(posedge clk);
    #1 check("lat.early_update", 32'(bus.update), 32'd0);
    @(posedge clk);
    #1 check("lat.update", 32'(bus.update), 32'(eu));
    check("lat.ki", 32'(bus.ki), 32'(m_regs[1]));
    @(posedge clk);
    #1 check("lat.update_1cyc", 32'(bus.update), 32'd0);
    settle_check("w0142", ub, eb, eu, ee);
`ifdef SPI_PARAM_SHADOW_EN
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'hFF00, 16, eu, ee);
    send(16'hFF00, 16);
    settle_check("commit", ub, eb, eu, ee);
    check("commit.ki", 32'(bus.ki), 32'h42);
`endif

    // Short then long frame
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0033, 15, eu, ee);
    send(16'h0033, 15);
    model_frame(16'h0033, 17, eu2, ee2);
    repeat (8) @(negedge clk);
    send(16'h0033, 17);
    settle_check("short_long", ub, eb, eu + eu2, ee + ee2);

    // Address out of range, and zero-length frame
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0512, 16, eu, ee);
    send(16'h0512, 16);
    settle_check("addr5", ub, eb, eu, ee);
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0001, 0, eu, ee);
    send(16'h0001, 0);
    settle_check("zero_len", ub, eb, eu, ee);

    // Reset after 8 sck of a frame
    eb = err_cnt;
    @(negedge clk);
    bus.cs = 1'b0;
    bus.frame = 16'h03AA;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.sck = 1'b1;
      repeat (2) @(negedge clk);
      bus.sck = 1'b0;
      repeat (2) @(negedge clk);
    end
    rst_n = 1'b0;
    bus.cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 8'h00;
      m_shadow[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ub = upd_cnt;
    settle_check("midreset", ub, eb, 0, 0);
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0377, 16, eu, ee);
    send(16'h0377, 16);
    settle_check("w0377", ub, eb, eu, ee);

    // Back-to-back frames with a 1-clk cs-high gap
    ub = upd_cnt; eb = err_cnt;
    model_frame(16'h0011, 16, eu, ee);
    model_frame(16'h0222, 16, eu2, ee2);
    send(16'h0011, 16);
    send(16'h0222, 16);
    settle_check("b2b", ub, eb, eu + eu2, ee + ee2);

    // Randomized frames, including sck activity while cs is high
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2, 3: a = 8'($urandom_range(0, 3));
        4:          a = 8'h05;
        5:          a = 8'hFF;
        default:    a = 8'($urandom_range(0, 255));
      endcase
      w = {a, 8'($urandom_range(0, 255))};
      case ($urandom_range(0, 9))
        6:       nsck = 15;
        7:       nsck = 17;
        8:       nsck = 0;
        9:       nsck = 20;
        default: nsck = 16;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk); bus.sck = 1'b1;
          repeat (2) @(negedge clk); bus.sck = 1'b0;
        end
        repeat (3) @(negedge clk);
      end
      ub = upd_cnt; eb = err_cnt;
      model_frame(w, nsck, eu, ee);
      send(w, nsck);
      settle_check($sformatf("rnd%0d", n), ub, eb, eu, ee);
    end

    check("no_coincident_pulses", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
